iob_pwm_deadtime: RTL and testbench
===================================

Name: iob_pwm_deadtime

Overview:
- Downstream stage of the ROM-driven PWM generator. Consumes its single-ended `pwm_output` and produces a complementary high-side/low-side gate pair for a half-bridge.
- Inserts a programmable dead time so both switches are never on together.
- Swallows input pulses shorter than the dead time and flags each one.
- Runs in the PWM generator's clock domain; no input synchronizer.

Parameters:
- DT_W, 8, width of the dead-time count.
- DT_MIN, 1, floor applied to the programmed dead time; a value below DT_MIN is treated as DT_MIN. Must be ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  output enable; 0 forces both gates off.
- dead_time  input  DT_W  dead time in clk cycles; sampled only on entry to a dead state.
- pwm_in  input  1  PWM from the upstream generator, same clock domain.
- pwm_h  output  1  high-side gate, registered.
- pwm_l  output  1  low-side gate, registered.
- dt_active  output  1  1 while in a dead state, registered.
- pulse_drop  output  1  one-cycle strobe: an input level was shorter than the dead time and was swallowed.

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous and active-low.
- Reset (rst=0, asynchronous): state=OFF. pwm_h=0, pwm_l=0, dt_active=0, pulse_drop=0. Counter=0.
- Register map: none. All outputs come directly from registers and depend only on the state; there is no combinational path from inputs to outputs.
- Effective dead time: D = max(dead_time, DT_MIN), latched into the counter as D-1 on entry to DT_LH or DT_HL.

State outputs:
- OFF: h=0, l=0.
- LOW: h=0, l=1.
- DT_LH: h=0, l=0, dt_active=1.
- HIGH: h=1, l=0.
- DT_HL: h=0, l=0, dt_active=1.

Transitions, evaluated at each rising clk edge, highest priority first:
- en=0 from any state: go to OFF.
- OFF with en=1: if pwm_in=1 go to DT_LH, else go to DT_HL. A dead interval therefore always follows enable.
- LOW with pwm_in=1: go to DT_LH, load counter.
- HIGH with pwm_in=0: go to DT_HL, load counter.
- DT_LH:
  - pwm_in=0: return to LOW, pulse_drop=1 for one cycle.
  - counter=0: go to HIGH.
  - otherwise: decrement counter.
- DT_HL:
  - pwm_in=1: return to HIGH, pulse_drop=1 for one cycle.
  - counter=0: go to LOW.
  - otherwise: decrement counter.
- Exception: an abort out of a DT state entered from OFF goes to the opposite DT state and reloads the counter, instead of returning to LOW/HIGH.

Timing and invariants:
- Latency: for an edge on pwm_in sampled at clock edge n:
  - the active gate drops after edge n;
  - the opposite gate rises after edge n+D.
  - Both gates are low for exactly D cycles. The dead interval is never shorter than D.
- pwm_h and pwm_l are never both 1, including across en toggling, reset release and dead_time changes.
- Each output pulse width equals the input pulse width minus D.
- A dead_time change during a dead interval has no effect until the next dead-state entry.
- dead_time=0 with DT_MIN=1 gives one dead cycle.
- The counter never underflows; the counter=0 check precedes the decrement.
- Reset mid-operation: both gates drop asynchronously. After rst deassertion the block restarts from OFF.

Optional Feature:
- Macro: IOB_PWM_DEADTIME_FAULT_EN.
- When defined, adds three ports:
  - fault_in, input, 1: active-high trip.
  - fault_clr, input, 1: clear request.
  - fault, output, 1: registered; high while in FAULT.
- FAULT state:
  - Entered from any state on the edge after fault_in=1, with priority over en.
  - Outputs: h=0, l=0, fault=1.
  - Stays latched until an edge with fault_clr=1 and fault_in=0, then goes to OFF.
  - fault_clr while fault_in=1 is ignored.
  - Reset value of fault is 0.
- When not defined: the ports and FAULT state do not exist and behaviour is as above.

Test Plan:
- Reset/enable: rst=0 → all outputs 0. Release rst, en=1, pwm_in=0, dead_time=4 → 4 cycles with h=l=0 and dt_active=1, then pwm_l=1.
- Nominal: dead_time=4, pwm_in high for 20 cycles → pwm_l falls after the sampling edge, pwm_h high for exactly 16 cycles, ≥4 dead cycles around each edge.
- Swallow: dead_time=6, pwm_in high for 3 cycles → pwm_h never asserts, pulse_drop high for 1 cycle, pwm_l returns after 3 dead cycles.
- Minimum: dead_time=0, DT_MIN=1, square wave with period 8 → exactly 1 dead cycle per edge, pwm_h high for 3 cycles per period.
- Disable mid-pulse: en→0 while in HIGH → pwm_h=0 after the next edge. en→1 with pwm_in=1 → D dead cycles, then pwm_h.
- Fault (IOB_PWM_DEADTIME_FAULT_EN): fault_in pulse during HIGH → h=l=0 and fault=1. fault_clr while fault_in=1 → fault stays 1. fault_clr after fault_in drops → OFF, then dead interval, then normal operation.
- Checker, running in all tests: assertion on every cycle that pwm_h & pwm_l is never 1.

Source files
------------

// File: rtl/iob_pwm_deadtime.sv
// iob_pwm_deadtime: complementary gate driver with programmable dead time.
// Turns the single-ended PWM from the upstream generator into a high-side /
// low-side pair with a dead interval between them. Input levels shorter
// than the dead time are swallowed and flagged with a one-cycle strobe.
//
// Optional fault latch: define IOB_PWM_DEADTIME_FAULT_EN to add the
// fault_in / fault_clr / fault ports and the latched FAULT state.
module iob_pwm_deadtime #(
    parameter int DT_W   = 8,
    parameter int DT_MIN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DT_W-1:0] dead_time,
    input  logic            pwm_in,
`ifdef IOB_PWM_DEADTIME_FAULT_EN
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            fault,
`endif
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            dt_active,
    output logic            pulse_drop
);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_LOW   = 3'd1;
    localparam logic [2:0] S_DT_LH = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DT_HL = 3'd4;
`ifdef IOB_PWM_DEADTIME_FAULT_EN
    localparam logic [2:0] S_FAULT = 3'd5;
`endif

    localparam logic [DT_W-1:0] DT_MIN_V = DT_W'(DT_MIN);
    localparam logic [DT_W-1:0] ONE      = DT_W'(1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nxt;
    logic [DT_W-1:0] cnt_load;
    logic            from_off;
    logic            from_off_nxt;
    logic            drop_nxt;

    // Effective dead time clamped to DT_MIN, stored as D-1 so that the
    // counter reaching zero marks the last dead cycle.
    always_comb begin
        cnt_load = ((dead_time < DT_MIN_V) ? DT_MIN_V : dead_time) - ONE;
    end

    // Next-state logic. from_off marks a dead interval that began from OFF:
    // neither gate has been on yet, so an aborted interval flips to the
    // opposite dead state instead of falling back to a gate-on state.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        from_off_nxt = from_off;
        drop_nxt     = 1'b0;
`ifdef IOB_PWM_DEADTIME_FAULT_EN
        if (fault_in) begin
            state_nxt = S_FAULT;
        end else if (state == S_FAULT) begin
            if (fault_clr) begin
                state_nxt = S_OFF;
            end
        end else
`endif
        if (!en) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    from_off_nxt = 1'b1;
                    cnt_nxt      = cnt_load;
                    state_nxt    = pwm_in ? S_DT_LH : S_DT_HL;
                end
                S_LOW: begin
                    if (pwm_in) begin
                        from_off_nxt = 1'b0;
                        cnt_nxt      = cnt_load;
                        state_nxt    = S_DT_LH;
                    end
                end
                S_HIGH: begin
                    if (!pwm_in) begin
                        from_off_nxt = 1'b0;
                        cnt_nxt      = cnt_load;
                        state_nxt    = S_DT_HL;
                    end
                end
                S_DT_LH: begin
                    if (!pwm_in) begin
                        drop_nxt = 1'b1;
                        if (from_off) begin
                            cnt_nxt   = cnt_load;
                            state_nxt = S_DT_HL;
                        end else begin
                            state_nxt = S_LOW;
                        end
                    end else if (cnt == '0) begin
                        state_nxt = S_HIGH;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                S_DT_HL: begin
                    if (pwm_in) begin
                        drop_nxt = 1'b1;
                        if (from_off) begin
                            cnt_nxt   = cnt_load;
                            state_nxt = S_DT_LH;
                        end else begin
                            state_nxt = S_HIGH;
                        end
                    end else if (cnt == '0) begin
                        state_nxt = S_LOW;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                end
            endcase
        end
    end

    // State, counter and registered outputs; outputs are decoded from the
    // next state so they line up with the state register each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_OFF;
            cnt        <= '0;
            from_off   <= 1'b0;
            pwm_h      <= 1'b0;
            pwm_l      <= 1'b0;
            dt_active  <= 1'b0;
            pulse_drop <= 1'b0;
`ifdef IOB_PWM_DEADTIME_FAULT_EN
            fault      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            from_off   <= from_off_nxt;
            pwm_h      <= (state_nxt == S_HIGH);
            pwm_l      <= (state_nxt == S_LOW);
            dt_active  <= (state_nxt == S_DT_LH) || (state_nxt == S_DT_HL);
            pulse_drop <= drop_nxt;
`ifdef IOB_PWM_DEADTIME_FAULT_EN
            fault      <= (state_nxt == S_FAULT);
`endif
        end
    end

endmodule

// File: tb/tb_iob_pwm_deadtime.sv
// Directed bench for iob_pwm_deadtime: each step drives inputs, queues the
// expected {pwm_h, pwm_l, dt_active, pulse_drop} for after the next edge,
// and checks it one time unit after that edge.
module tb_iob_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] dead_time;
    logic       pwm_in;
    logic       pwm_h;
    logic       pwm_l;
    logic       dt_active;
    logic       pulse_drop;
`ifdef IOB_PWM_DEADTIME_FAULT_EN
    logic       fault_in;
    logic       fault_clr;
    logic       fault;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] exp_q[$];

    localparam logic [3:0] O_OFF   = 4'b0000;
    localparam logic [3:0] O_HIGH  = 4'b1000;
    localparam logic [3:0] O_LOW   = 4'b0100;
    localparam logic [3:0] O_DT    = 4'b0010;
    localparam logic [3:0] O_DRP_L = 4'b0101;
    localparam logic [3:0] O_DRP_H = 4'b1001;

    iob_pwm_deadtime #(.DT_W(8), .DT_MIN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dead_time  (dead_time),
        .pwm_in     (pwm_in),
`ifdef IOB_PWM_DEADTIME_FAULT_EN
        .fault_in   (fault_in),
        .fault_clr  (fault_clr),
        .fault      (fault),
`endif
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l),
        .dt_active  (dt_active),
        .pulse_drop (pulse_drop)
    );

    always #5 clk = ~clk;

    // Shoot-through checker on every falling edge.
    always @(negedge clk) begin
        compared++;
        assert (!(pwm_h === 1'b1 && pwm_l === 1'b1)) else begin
            mismatched++;
            $error("FAIL overlap: pwm_h=%b pwm_l=%b required not both 1", pwm_h, pwm_l);
        end
    end

    task automatic step(input logic e, input logic p, input logic [7:0] d,
                        input logic [3:0] exp, input string tag);
        logic [3:0] want;
        logic [3:0] got;
        en        = e;
        pwm_in    = p;
        dead_time = d;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = {pwm_h, pwm_l, dt_active, pulse_drop};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: scoreboard empty, got %b", tag, got);
        end else begin
            want = exp_q.pop_front();
            assert (got === want) else begin
                mismatched++;
                $error("FAIL %s: got h,l,dt,pd=%b required %b", tag, got, want);
            end
        end
    endtask

    task automatic check_bit(input logic got, input logic want, input string tag);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: got %b required %b", tag, got, want);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        pwm_in    = 1'b0;
        dead_time = 8'd4;
`ifdef IOB_PWM_DEADTIME_FAULT_EN
        fault_in  = 1'b0;
        fault_clr = 1'b0;
`endif
        #2 rst = 1'b0;

        // Reset state
        repeat (2) step(1'b0, 1'b0, 8'd4, O_OFF, "reset");
`ifdef IOB_PWM_DEADTIME_FAULT_EN
        check_bit(fault, 1'b0, "reset_fault");
`endif
        rst = 1'b1;

        // Enable with pwm_in=0: 4 dead cycles then low side
        repeat (4) step(1'b1, 1'b0, 8'd4, O_DT, "en_dead");
        repeat (2) step(1'b1, 1'b0, 8'd4, O_LOW, "en_low");

        // Nominal 20-cycle high pulse with D=4
        repeat (4)  step(1'b1, 1'b1, 8'd4, O_DT, "nom_dead_lh");
        repeat (16) step(1'b1, 1'b1, 8'd4, O_HIGH, "nom_high");
        repeat (4)  step(1'b1, 1'b0, 8'd4, O_DT, "nom_dead_hl");
        repeat (2)  step(1'b1, 1'b0, 8'd4, O_LOW, "nom_low");

        // Swallow a 3-cycle pulse with D=6
        repeat (3) step(1'b1, 1'b1, 8'd6, O_DT, "swl_dead");
        step(1'b1, 1'b0, 8'd6, O_DRP_L, "swl_drop");
        repeat (2) step(1'b1, 1'b0, 8'd6, O_LOW, "swl_low");

        // dead_time change inside a dead interval is ignored (D=2 latched)
        step(1'b1, 1'b1, 8'd2, O_DT, "dtchg_dead0");
        step(1'b1, 1'b1, 8'd7, O_DT, "dtchg_dead1");
        step(1'b1, 1'b1, 8'd7, O_HIGH, "dtchg_high");

        // Swallow a 1-cycle low glitch from HIGH with D=7
        step(1'b1, 1'b0, 8'd7, O_DT, "swlh_dead");
        step(1'b1, 1'b1, 8'd7, O_DRP_H, "swlh_drop");
        step(1'b1, 1'b1, 8'd7, O_HIGH, "swlh_high");

        // dead_time=0 clamps to 1; period-8 square wave
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 8'd0, O_DT, "min_dead_hl");
            repeat (3) step(1'b1, 1'b0, 8'd0, O_LOW, "min_low");
            step(1'b1, 1'b1, 8'd0, O_DT, "min_dead_lh");
            repeat (3) step(1'b1, 1'b1, 8'd0, O_HIGH, "min_high");
        end

        // Disable mid-pulse, then re-enable with pwm_in=1
        repeat (2) step(1'b0, 1'b1, 8'd4, O_OFF, "dis_off");
        repeat (4) step(1'b1, 1'b1, 8'd4, O_DT, "reen_dead");
        repeat (2) step(1'b1, 1'b1, 8'd4, O_HIGH, "reen_high");

        // Asynchronous reset while HIGH drops gates without a clock edge
        rst = 1'b0;
        #1;
        check_bit(pwm_h, 1'b0, "areset_h");
        check_bit(dt_active, 1'b0, "areset_dt");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b1, 8'd3, O_OFF, "post_rst_off");
        repeat (3) step(1'b1, 1'b1, 8'd3, O_DT, "post_rst_dead");
        repeat (2) step(1'b1, 1'b1, 8'd3, O_HIGH, "post_rst_high");

`ifdef IOB_PWM_DEADTIME_FAULT_EN
        // Fault trip while HIGH, clear ignored while tripped, then recover
        fault_in = 1'b1;
        step(1'b1, 1'b1, 8'd3, O_OFF, "flt_trip");
        check_bit(fault, 1'b1, "flt_trip_fault");
        fault_in = 1'b0;
        step(1'b1, 1'b1, 8'd3, O_OFF, "flt_latched");
        check_bit(fault, 1'b1, "flt_latched_fault");
        fault_in  = 1'b1;
        fault_clr = 1'b1;
        step(1'b1, 1'b1, 8'd3, O_OFF, "flt_clr_ignored");
        check_bit(fault, 1'b1, "flt_clr_ignored_fault");
        fault_in = 1'b0;
        step(1'b1, 1'b1, 8'd3, O_OFF, "flt_clr");
        check_bit(fault, 1'b0, "flt_clr_fault");
        fault_clr = 1'b0;
        repeat (3) step(1'b1, 1'b1, 8'd3, O_DT, "flt_rec_dead");
        repeat (2) step(1'b1, 1'b1, 8'd3, O_HIGH, "flt_rec_high");
`endif

        step(1'b0, 1'b0, 8'd3, O_OFF, "final_off");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
